// File: rtl/fp32_sub_seq_pkg.sv
// fp32_sub_seq_pkg: shared widths, constants, FSM states and unpacked operand types.
package fp32_pkg;
  localparam int FRAC_W = 23;
  localparam int EXP_W = 8;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_ZERO = 32'h0;
  localparam logic [30:0] INF_MAG = 31'h7F800000;
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W+1:0] mant25;
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_unp_t;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [FRAC_W+1:0] mant25;
  } fp_op_t;
endpackage

// File: rtl/fp32_sub_seq_if.sv
// fp32_sub_seq_if: operand/result handshake bundle for the sequential subtractor.
interface fp32_sub_seq_if;
  logic in_valid;
  logic in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic out_valid;
  logic out_ready;
  logic [31:0] result;
  logic busy;
  modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, result, busy);
  modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, result, busy);
endinterface

// File: rtl/fp32_sub_seq_unpack.sv
// fp32_unpack: splits an IEEE single into sign/exponent/25-bit mantissa with denormals flushed to zero.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [31:0] i_word,
  output fp_unp_t     o_u
);
  logic w_exp_max;
  logic w_zero;
  assign w_exp_max = i_word[30:23] == EXP_MAX;
  assign w_zero = i_word[30:23] == '0;
  always_comb begin
    o_u.sign = i_word[31];
    o_u.exp = i_word[30:23];
    o_u.mant25 = w_zero ? '0 : {2'b01, i_word[FRAC_W-1:0]};
    o_u.is_zero = w_zero;
    o_u.is_inf = w_exp_max && i_word[FRAC_W-1:0] == '0;
    o_u.is_nan = w_exp_max && i_word[FRAC_W-1:0] != '0;
  end
endmodule

// File: rtl/fp32_sub_seq.sv
// fp32_sub_seq: multi-cycle truncating IEEE single subtractor computing a + (-b),
// with fixed align/add cycles and one-bit-per-cycle normalization.
module fp32_sub_seq
  import fp32_pkg::*;
(
  input logic clk,
  input logic rst,
  fp32_sub_seq_if.slave bus
);
  fp_unp_t w_ua, w_ub;
  fp_op_t r_a, r_b, w_x, w_y;
  state_t r_state, w_next;
  logic r_sign, r_eff_sub;
  logic [EXP_W-1:0] r_exp, w_diff, w_exp_inc, w_exp_dec;
  logic [FRAC_W+1:0] r_mx, r_my, r_m, w_y_sh, w_sum;
  logic [31:0] r_result, w_spec_res;
  logic w_special, w_a_big, w_norm_done;
  fp32_unpack u_unpack_a (.i_word(bus.a), .o_u(w_ua));
  fp32_unpack u_unpack_b (.i_word({~bus.b[31], bus.b[30:0]}), .o_u(w_ub));
  assign w_special = w_ua.is_nan | w_ub.is_nan | w_ua.is_inf | w_ub.is_inf | w_ua.is_zero | w_ub.is_zero;
  // Both infinite with opposite effective signs is inf - inf, hence NaN.
  assign w_spec_res = (w_ua.is_nan | w_ub.is_nan | (w_ua.is_inf & w_ub.is_inf & (w_ua.sign ^ w_ub.sign))) ? QNAN :
                      w_ua.is_inf ? {w_ua.sign, INF_MAG} :
                      w_ub.is_inf ? {w_ub.sign, INF_MAG} :
                      (w_ua.is_zero & w_ub.is_zero) ? POS_ZERO :
                      w_ua.is_zero ? {w_ub.sign, bus.b[30:0]} : bus.a;
  assign w_a_big = {r_a.exp, r_a.mant25} >= {r_b.exp, r_b.mant25};
  assign w_x = w_a_big ? r_a : r_b;
  assign w_y = w_a_big ? r_b : r_a;
  assign w_diff = w_x.exp - w_y.exp;
  assign w_y_sh = w_diff >= 8'd25 ? '0 : w_y.mant25 >> w_diff;
  assign w_sum = r_eff_sub ? r_mx - r_my : r_mx + r_my;
  assign w_exp_inc = r_exp + 8'd1;
  assign w_exp_dec = r_exp - 8'd1;
  assign w_norm_done = r_m[24] ? w_exp_inc == EXP_MAX : !r_m[23] ? w_exp_dec == '0 : 1'b1;
  assign bus.in_ready = r_state == IDLE;
  assign bus.busy = r_state != IDLE;
  assign bus.out_valid = r_state == DONE;
  assign bus.result = r_result;
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:  w_next = bus.in_valid ? (w_special ? DONE : ALIGN) : IDLE;
      ALIGN: w_next = ADD;
      ADD:   w_next = w_sum == '0 ? DONE : NORM;
      NORM:  w_next = w_norm_done ? DONE : NORM;
      DONE:  w_next = bus.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_result <= POS_ZERO;
      r_a <= '0;
      r_b <= '0;
      r_sign <= 1'b0;
      r_eff_sub <= 1'b0;
      r_exp <= '0;
      r_mx <= '0;
      r_my <= '0;
      r_m <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_a <= '{w_ua.sign, w_ua.exp, w_ua.mant25};
          r_b <= '{w_ub.sign, w_ub.exp, w_ub.mant25};
          if (w_special) r_result <= w_spec_res;
        end
        ALIGN: begin
          r_sign <= w_x.sign;
          r_exp <= w_x.exp;
          r_mx <= w_x.mant25;
          r_my <= w_y_sh;
          r_eff_sub <= r_a.sign ^ r_b.sign;
        end
        ADD: begin
          r_m <= w_sum;
          if (w_sum == '0) r_result <= POS_ZERO;
        end
        NORM: if (r_m[24]) begin
          r_m <= r_m >> 1;
          r_exp <= w_exp_inc;
          if (w_exp_inc == EXP_MAX) r_result <= {r_sign, INF_MAG};
        end else if (!r_m[23]) begin
          r_m <= r_m << 1;
          r_exp <= w_exp_dec;
          if (w_exp_dec == '0) r_result <= POS_ZERO;
        end else begin
          r_result <= {r_sign, r_exp, r_m[FRAC_W-1:0]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp32_sub_seq.sv
// tb_fp32_sub_seq: directed scoreboard bench for fp32_sub_seq (results and accept-to-valid latency).
module tb_fp32_sub_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int lat_q[$];
  fp32_sub_seq_if bus ();
  fp32_sub_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  // Latency counts the accept edge as 1; hold keeps out_ready low that many extra cycles.
  task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] er, input int el, input int hold);
    int lat;
    logic [31:0] er_q;
    int el_q;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    bus.a = av;
    bus.b = bv;
    bus.in_valid = 1'b1;
    exp_q.push_back(er);
    lat_q.push_back(el);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    er_q = exp_q.pop_front();
    el_q = lat_q.pop_front();
    chk({tag, "_result"}, bus.result, er_q);
    chk({tag, "_latency"}, lat, el_q);
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        bus.a = 32'h3F800000;
        bus.b = 32'h40000000;
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      chk({tag, "_hold_state"}, {bus.result, 29'd0, bus.out_valid, bus.in_ready, bus.busy}, {er_q, 29'd0, 3'b101});
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({tag, "_release"}, {30'd0, bus.in_ready, bus.out_valid}, 32'd2);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {bus.result, 29'd0, bus.in_ready, bus.out_valid, bus.busy}, {32'h0, 29'd0, 3'b100});
    rst = 1'b0;
    op("sub_3m1", 32'h40400000, 32'h3F800000, 32'h40000000, 4, 0);
    op("sub_1m1p5", 32'h3F800000, 32'h3FC00000, 32'hBF000000, 5, 0);
    op("sub_1mneg1", 32'h3F800000, 32'hBF800000, 32'h40000000, 5, 0);
    op("cancel", 32'h3F800000, 32'h3F800000, 32'h00000000, 3, 0);
    op("inf_m_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1, 0);
    op("inf_m_ninf", 32'h7F800000, 32'hFF800000, 32'h7F800000, 1, 0);
    op("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1, 0);
    op("one_m_inf", 32'h3F800000, 32'h7F800000, 32'hFF800000, 1, 0);
    op("zero_m_b", 32'h00000000, 32'h3F800000, 32'hBF800000, 1, 0);
    op("a_m_zero", 32'h40400000, 32'h80000000, 32'h40400000, 1, 0);
    op("denorm", 32'h00000001, 32'h00000001, 32'h00000000, 1, 0);
    op("far_align", 32'h3F800000, 32'h30800000, 32'h3F800000, 4, 0);
    op("overflow", 32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 4, 0);
    op("underflow", 32'h00800000, 32'h00C00000, 32'h00000000, 4, 0);
    op("backpressure", 32'h40400000, 32'h3F800000, 32'h40000000, 4, 10);
    @(negedge clk);
    bus.a = 32'h3F800000;
    bus.b = 32'h3FC00000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("rst_mid_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_mid_state", {bus.result, 29'd0, bus.in_ready, bus.out_valid, bus.busy}, {32'h0, 29'd0, 3'b100});
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(posedge clk);
        #1 if (bus.out_valid || bus.result != 32'h0) seen++;
      end
      chk("rst_no_stale", seen, 0);
    end
    op("after_reset", 32'h40400000, 32'h3F800000, 32'h40000000, 4, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
